branch_seq: RTL and testbench

Branch/jump sub-sequencer for the multicycle CPU. The main control unit hands off each conditional branch (beq, bne, ble, bgt) and each jump (j, jal) after decode. This block then drives the ALU operand selects, the ALUOut load, the PC source and PC write enable, and the link register write. It resolves the branch condition itself from the ALU Zero/Gt flags and returns a one-cycle `done` pulse.

---
 rtl/branch_seq.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_branch_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_seq.sv
// -----------------------------------------------------------------------------
// branch_seq
//
// Branch/jump sub-sequencer for the multicycle CPU. The main control unit
// passes each conditional branch (beq, bne, ble, bgt) and each jump (j, jal)
// to this block after decode. The block then sequences the ALU operand
// selects, the ALUOut load, the PC source/write and the link register write.
// It resolves the branch condition from the ALU zero/gt flags and ends every
// sequence with a one-cycle done pulse.
//
// Parameters
//   ALU_OP_ADD  ALU opcode used for the branch-target add
//   ALU_OP_SUB  ALU opcode used for the compare
//   CMP_WAIT    extra COMPARE cycles (0..3) before RESOLVE, for ALU settle
//
// Ports
//   clk           clock, rising edge
//   reset         synchronous active-high reset
//   start         one-cycle request, sampled only in IDLE
//   opcode[5:0]   instruction opcode, latched when start is accepted
//   zero, gt      ALU flags (A-B == 0, signed A > B), used in RESOLVE only
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//   illegal       qualifies done when the latched opcode is unsupported
//   alu_srca      0 = PC, 1 = A register
//   alu_srcb[1:0] 00 = B register, 11 = signext(imm)<<2
//   alu_op[2:0]   ALU operation
//   aluout_write  load ALUOut
//   pc_source[1:0] 01 = ALUOut, 10 = jump target
//   pc_write      PC load enable
//   reg_write     register file write
//   link_sel      destination $ra, write data PC (jal)
//   taken         result of the last resolved branch
//   br_taken_cnt, br_nt_cnt  saturating 16-bit branch statistics
//
// Optional feature: define BRANCH_STATS_EN to add the two statistics counters
// and their ports. Without it the counters and ports do not exist.
// -----------------------------------------------------------------------------
module branch_seq #(
    parameter logic [2:0]  ALU_OP_ADD = 3'b001,
    parameter logic [2:0]  ALU_OP_SUB = 3'b010,
    parameter int unsigned CMP_WAIT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        gt,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        alu_srca,
    output logic [1:0]  alu_srcb,
    output logic [2:0]  alu_op,
    output logic        aluout_write,
    output logic [1:0]  pc_source,
    output logic        pc_write,
    output logic        reg_write,
    output logic        link_sel,
    output logic        taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] br_taken_cnt,
    output logic [15:0] br_nt_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Opcode encodings
    // -------------------------------------------------------------------------
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_BLE = 6'h06;
    localparam logic [5:0] OP_BGT = 6'h07;

    // Operand select encodings
    localparam logic       SRCA_PC    = 1'b0;
    localparam logic       SRCA_A     = 1'b1;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // The wait counter is only two bits wide since CMP_WAIT is limited to 0..3.
    localparam logic [1:0] CMP_WAIT_L = 2'(CMP_WAIT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TARGET  = 3'd1,
        S_COMPARE = 3'd2,
        S_RESOLVE = 3'd3,
        S_LINK    = 3'd4,
        S_JUMP    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      state_reg,    state_next;
    logic [5:0]  opcode_reg,   opcode_next;
    logic        illegal_reg,  illegal_next;
    logic [1:0]  wait_cnt_reg, wait_cnt_next;
    logic        taken_reg,    taken_next;

    // Branch condition evaluated from the latched opcode and the live flags.
    // Only meaningful in RESOLVE; elsewhere it is ignored.
    logic        cond_taken;
    logic        resolving;

    always_comb begin
        cond_taken = 1'b0;
        case (opcode_reg)
            OP_BEQ:  cond_taken = zero;
            OP_BNE:  cond_taken = ~zero;
            OP_BLE:  cond_taken = ~gt;
            OP_BGT:  cond_taken = gt;
            default: cond_taken = 1'b0;
        endcase
    end

    assign resolving = (state_reg == S_RESOLVE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            opcode_reg   <= 6'd0;
            illegal_reg  <= 1'b0;
            wait_cnt_reg <= 2'd0;
            taken_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            opcode_reg   <= opcode_next;
            illegal_reg  <= illegal_next;
            wait_cnt_reg <= wait_cnt_next;
            taken_reg    <= taken_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // Defaults: hold registers, every output inactive.
        state_next    = state_reg;
        opcode_next   = opcode_reg;
        illegal_next  = illegal_reg;
        wait_cnt_next = 2'd0;
        taken_next    = taken_reg;

        busy          = 1'b1;
        done          = 1'b0;
        illegal       = 1'b0;
        alu_srca      = SRCA_PC;
        alu_srcb      = SRCB_B;
        alu_op        = 3'b000;
        aluout_write  = 1'b0;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        link_sel      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    opcode_next  = opcode;
                    illegal_next = 1'b0;
                    case (opcode)
                        OP_BEQ, OP_BNE, OP_BLE, OP_BGT: state_next = S_TARGET;
                        OP_J:                           state_next = S_JUMP;
                        OP_JAL:                         state_next = S_LINK;
                        default: begin
                            illegal_next = 1'b1;
                            state_next   = S_DONE;
                        end
                    endcase
                end
            end

            // Branch target PC + (signext(imm) << 2) into ALUOut. PC already
            // holds PC+4 from fetch, which is the base the ISA expects.
            S_TARGET: begin
                alu_srca     = SRCA_PC;
                alu_srcb     = SRCB_IMMSH;
                alu_op       = ALU_OP_ADD;
                aluout_write = 1'b1;
                state_next   = S_COMPARE;
            end

            // A - B compare. ALUOut must not be overwritten here since it
            // holds the branch target.
            S_COMPARE: begin
                alu_srca = SRCA_A;
                alu_srcb = SRCB_B;
                alu_op   = ALU_OP_SUB;
                if (wait_cnt_reg == CMP_WAIT_L) begin
                    state_next = S_RESOLVE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 2'd1;
                end
            end

            // Operands stay on the ALU so the flags remain valid; the PC load
            // follows the flags combinationally in this single cycle.
            S_RESOLVE: begin
                alu_srca   = SRCA_A;
                alu_srcb   = SRCB_B;
                alu_op     = ALU_OP_SUB;
                pc_source  = PCSRC_ALUOUT;
                pc_write   = cond_taken;
                taken_next = cond_taken;
                state_next = S_DONE;
            end

            S_LINK: begin
                reg_write  = 1'b1;
                link_sel   = 1'b1;
                state_next = S_JUMP;
            end

            S_JUMP: begin
                pc_source  = PCSRC_JUMP;
                pc_write   = 1'b1;
                state_next = S_DONE;
            end

            S_DONE: begin
                done       = 1'b1;
                illegal    = illegal_reg;
                state_next = S_IDLE;
            end

            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    assign taken = taken_reg;

`ifdef BRANCH_STATS_EN
    // -------------------------------------------------------------------------
    // Branch statistics: one saturating counter per outcome. Index 0 counts
    // taken branches, index 1 counts not-taken branches.
    // -------------------------------------------------------------------------
    logic [15:0] br_taken_cnt_reg;
    logic [15:0] br_nt_cnt_reg;
    logic [1:0]  stat_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_stat_inc
            // gi == 0 counts cond_taken, gi == 1 counts its complement.
            assign stat_inc[gi] = resolving & (cond_taken ^ (gi != 0));
        end
    endgenerate

    // Counters only assign when they advance, so a saturated value is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_taken_cnt_reg <= 16'd0;
        end else if (stat_inc[0] && (br_taken_cnt_reg != 16'hFFFF)) begin
            br_taken_cnt_reg <= br_taken_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_nt_cnt_reg <= 16'd0;
        end else if (stat_inc[1] && (br_nt_cnt_reg != 16'hFFFF)) begin
            br_nt_cnt_reg <= br_nt_cnt_reg + 16'd1;
        end
    end

    assign br_taken_cnt = br_taken_cnt_reg;
    assign br_nt_cnt    = br_nt_cnt_reg;
`endif

endmodule

// File: tb/tb_branch_seq.sv
// -----------------------------------------------------------------------------
// tb_branch_seq
//
// Directed bench for branch_seq. Two instances share the clock, reset and
// opcode/flag inputs: dut0 uses CMP_WAIT=0, dut2 uses CMP_WAIT=2. For every
// sequence the expected per-cycle output vector is pushed to a queue when
// start is driven, then popped and compared one cycle at a time.
// -----------------------------------------------------------------------------
module tb_branch_seq;

    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] SUB = 3'b010;

    localparam int S_IDLE = 0, S_TARGET = 1, S_CMP = 2, S_RES = 3,
                   S_LINK = 4, S_JUMP = 5, S_DONE = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start0, start2;
    logic [5:0] opcode;
    logic       zero, gt;

    logic       busy0, done0, ill0, srca0, aw0, pcw0, rw0, ls0, tk0;
    logic [1:0] srcb0, ps0;
    logic [2:0] aop0;
    logic       busy2, done2, ill2, srca2, aw2, pcw2, rw2, ls2, tk2;
    logic [1:0] srcb2, ps2;
    logic [2:0] aop2;
`ifdef BRANCH_STATS_EN
    logic [15:0] tcnt0, ncnt0, tcnt2, ncnt2;
`endif

    branch_seq #(.ALU_OP_ADD(ADD), .ALU_OP_SUB(SUB), .CMP_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .opcode(opcode),
        .zero(zero), .gt(gt), .busy(busy0), .done(done0), .illegal(ill0),
        .alu_srca(srca0), .alu_srcb(srcb0), .alu_op(aop0),
        .aluout_write(aw0), .pc_source(ps0), .pc_write(pcw0),
        .reg_write(rw0), .link_sel(ls0), .taken(tk0)
`ifdef BRANCH_STATS_EN
        , .br_taken_cnt(tcnt0), .br_nt_cnt(ncnt0)
`endif
    );

    branch_seq #(.ALU_OP_ADD(ADD), .ALU_OP_SUB(SUB), .CMP_WAIT(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .opcode(opcode),
        .zero(zero), .gt(gt), .busy(busy2), .done(done2), .illegal(ill2),
        .alu_srca(srca2), .alu_srcb(srcb2), .alu_op(aop2),
        .aluout_write(aw2), .pc_source(ps2), .pc_write(pcw2),
        .reg_write(rw2), .link_sel(ls2), .taken(tk2)
`ifdef BRANCH_STATS_EN
        , .br_taken_cnt(tcnt2), .br_nt_cnt(ncnt2)
`endif
    );

    // Observed output vectors, field order matches expv().
    logic [14:0] obs0, obs2;
    assign obs0 = {busy0, done0, ill0, srca0, srcb0, aop0, aw0, ps0, pcw0, rw0, ls0};
    assign obs2 = {busy2, done2, ill2, srca2, srcb2, aop2, aw2, ps2, pcw2, rw2, ls2};

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [14:0] exp_q[$];
    logic        exp_taken0 = 1'b0;
    logic        exp_taken2 = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expd);
        total++;
        assert (obs === expd) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
        end
    endtask

    // Expected outputs for one state of the sequencer.
    function automatic logic [14:0] expv(input int st, input bit ill, input bit tk);
        logic       b, d, il, sa, aw, pw, rw, ls;
        logic [1:0] sb, ps;
        logic [2:0] op;
        b = (st != S_IDLE); d = 0; il = 0; sa = 0; aw = 0; pw = 0; rw = 0; ls = 0;
        sb = 2'b00; ps = 2'b00; op = 3'b000;
        case (st)
            S_TARGET: begin sb = 2'b11; op = ADD; aw = 1; end
            S_CMP:    begin sa = 1; op = SUB; end
            S_RES:    begin sa = 1; op = SUB; ps = 2'b01; pw = tk; end
            S_LINK:   begin rw = 1; ls = 1; end
            S_JUMP:   begin ps = 2'b10; pw = 1; end
            S_DONE:   begin d = 1; il = ill; end
            default:  ;
        endcase
        return {b, d, il, sa, sb, op, aw, ps, pw, rw, ls};
    endfunction

    function automatic bit model_taken(input logic [5:0] op, input bit z, input bit g);
        case (op)
            6'h04:   return z;
            6'h05:   return !z;
            6'h06:   return !g;
            6'h07:   return g;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_trace(input bit sel, input logic [5:0] op, input bit z, input bit g);
        int w;
        bit tk;
        w  = sel ? 2 : 0;
        tk = model_taken(op, z, g);
        case (op)
            6'h04, 6'h05, 6'h06, 6'h07: begin
                exp_q.push_back(expv(S_TARGET, 0, 0));
                for (int i = 0; i <= w; i++) exp_q.push_back(expv(S_CMP, 0, 0));
                exp_q.push_back(expv(S_RES, 0, tk));
                exp_q.push_back(expv(S_DONE, 0, 0));
                if (sel) exp_taken2 = tk; else exp_taken0 = tk;
            end
            6'h02: begin
                exp_q.push_back(expv(S_JUMP, 0, 0));
                exp_q.push_back(expv(S_DONE, 0, 0));
            end
            6'h03: begin
                exp_q.push_back(expv(S_LINK, 0, 0));
                exp_q.push_back(expv(S_JUMP, 0, 0));
                exp_q.push_back(expv(S_DONE, 0, 0));
            end
            default: exp_q.push_back(expv(S_DONE, 1, 0));
        endcase
    endtask

    // Runs one sequence starting at a negedge in IDLE and returns at the
    // negedge of the IDLE cycle following DONE, so calls chain back-to-back.
    // restart_at > 0 re-pulses start (with a j opcode) in that cycle.
    task automatic run(input bit sel, input string name, input logic [5:0] op,
                       input bit z, input bit g, input int restart_at);
        int          cyc;
        logic [14:0] e;
        opcode = op; zero = z; gt = g;
        if (sel) start2 = 1'b1; else start0 = 1'b1;
        #1;
        check({name, " c0"}, {1'b0, sel ? obs2 : obs0}, {1'b0, expv(S_IDLE, 0, 0)});
        push_trace(sel, op, z, g);
        @(negedge clk);
        start0 = 1'b0; start2 = 1'b0;
        cyc = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s c%0d", name, cyc), {1'b0, sel ? obs2 : obs0}, {1'b0, e});
            if (cyc == restart_at) begin
                opcode = 6'h02;
                if (sel) start2 = 1'b1; else start0 = 1'b1;
            end
            @(negedge clk);
            start0 = 1'b0; start2 = 1'b0;
            cyc++;
        end
        check({name, " idle"}, {1'b0, sel ? obs2 : obs0}, {1'b0, expv(S_IDLE, 0, 0)});
        check({name, " taken"}, {15'd0, sel ? tk2 : tk0}, {15'd0, sel ? exp_taken2 : exp_taken0});
        $display("txn %-12s dut%0d op=%h zero=%0d gt=%0d taken=%0d", name, sel ? 2 : 0, op, z, g,
                 sel ? tk2 : tk0);
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start2 = 1'b0;
        opcode = 6'h00; zero = 1'b0; gt = 1'b0;
        repeat (2) @(negedge clk);
        check("reset dut0", {1'b0, obs0}, 16'd0);
        check("reset dut2", {1'b0, obs2}, 16'd0);
        check("reset taken0", {15'd0, tk0}, 16'd0);
`ifdef BRANCH_STATS_EN
        check("reset tcnt0", tcnt0, 16'd0);
        check("reset ncnt0", ncnt0, 16'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // CMP_WAIT = 0 instance, back-to-back sequences.
        run(0, "beq_z1", 6'h04, 1, 0, 0);
        run(0, "bne_z1", 6'h05, 1, 0, 0);
        run(0, "bgt_g1", 6'h07, 0, 1, 0);
        run(0, "jal", 6'h03, 0, 0, 0);
        run(0, "j", 6'h02, 1, 1, 0);
        run(0, "illegal23", 6'h23, 1, 1, 0);
        run(0, "ble_g1", 6'h06, 0, 1, 0);
        run(0, "beq_z0", 6'h04, 0, 1, 0);
        run(0, "bne_z0", 6'h05, 0, 0, 0);

        // CMP_WAIT = 2 instance: start re-pulsed in COMPARE is ignored.
        run(1, "ble_g0_rst", 6'h06, 0, 0, 3);

        // Second run on dut2, reset asserted during COMPARE.
        opcode = 6'h06; zero = 1'b0; gt = 1'b0; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        @(negedge clk);
        check("pre-reset cmp", {1'b0, obs2}, {1'b0, expv(S_CMP, 0, 0)});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_taken0 = 1'b0; exp_taken2 = 1'b0;
        check("midrst outputs", {1'b0, obs2}, 16'd0);
        check("midrst taken", {15'd0, tk2}, 16'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("midrst quiet c%0d", i), {1'b0, obs2}, 16'd0);
        end
        $display("txn %-12s dut2 reset during COMPARE", "ble_reset");

`ifdef BRANCH_STATS_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_taken0 = 1'b0;
        run(0, "st_beq_t", 6'h04, 1, 0, 0);
        run(0, "st_bne_n", 6'h05, 1, 0, 0);
        run(0, "st_bgt_t", 6'h07, 0, 1, 0);
        run(0, "st_ble_n", 6'h06, 0, 1, 0);
        run(0, "st_ble_t", 6'h06, 0, 0, 0);
        check("stats taken", tcnt0, 16'd3);
        check("stats nt", ncnt0, 16'd2);
        force dut0.br_taken_cnt_reg = 16'hFFFF;
        #1;
        release dut0.br_taken_cnt_reg;
        run(0, "st_sat", 6'h04, 1, 0, 0);
        check("stats sat", tcnt0, 16'hFFFF);
        check("stats nt hold", ncnt0, 16'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
